// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_pkg
// Description : Shared types and constants for the ADC capture/phase path.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    typedef enum logic [1:0] {
        ST_PS_IDLE      = 2'd0,
        ST_PS_ISSUE     = 2'd1,
        ST_PS_WAIT_DONE = 2'd2,
        ST_PS_SETTLE    = 2'd3
    } ps_state_t;

    localparam int          PHASE_POS_DEFAULT = 56;
    localparam logic [13:0] ADC_TEST_PATTERN  = 14'h2A5C;

endpackage
`default_nettype wire

// File: rtl/adc_phase_stepper.sv
`default_nettype none
// ============================================================================
// Module      : adc_phase_stepper
// Description : Turns adjust_phase pulses into MMCM fine phase-shift steps.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_phase_stepper
    import adc_pkg::*;
#(
    parameter int       PHASE_POS     = PHASE_POS_DEFAULT,
    parameter int       STEPS_PER_POS = 1,
    parameter int       PEND_W        = 4,
    parameter int       DONE_TIMEOUT  = 64,
    parameter int       SETTLE_CYCLES = 8,
    parameter bit       INC_DIR       = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adjust_phase,
    input  logic              mmcm_locked,
    input  logic              clr_err,
    input  logic              psdone,
    output logic              psen,
    output logic              psincdec,
    output logic              busy,
    output logic [6:0]        phase_pos,
    output logic [PEND_W-1:0] pending,
    output logic              timeout_err,
    output logic              overflow_err
);

    localparam int              TMO_W    = $clog2(DONE_TIMEOUT + 1);
    localparam int              SET_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    ps_state_t         state_q, state_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic [6:0]        phase_pos_q, phase_pos_d;
    logic [7:0]        step_cnt_q, step_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic              overflow_err_q, overflow_err_d;

    logic              w_req;
    logic [7:0]        w_step_nxt;
    logic              w_pos_done;
    logic              w_tmo_hit;

    // Requests are only accepted while the MMCM is locked.
    assign w_req      = adjust_phase & mmcm_locked;
    assign w_step_nxt = step_cnt_q + 8'd1;
    assign w_pos_done = mmcm_locked && (state_q == ST_PS_WAIT_DONE) && psdone
                        && (w_step_nxt == 8'(STEPS_PER_POS));
    assign w_tmo_hit  = mmcm_locked && (state_q == ST_PS_WAIT_DONE) && !psdone
                        && (tmo_cnt_q == TMO_W'(DONE_TIMEOUT - 1));

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q;
        phase_pos_d    = phase_pos_q;
        step_cnt_d     = step_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        timeout_err_d  = clr_err ? 1'b0 : timeout_err_q;
        overflow_err_d = clr_err ? 1'b0 : overflow_err_q;

        case (state_q)
            ST_PS_IDLE: begin
                step_cnt_d = '0;
                if ((pending_q != '0) && mmcm_locked) begin
                    state_d = ST_PS_ISSUE;
                end
            end
            ST_PS_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_PS_WAIT_DONE;
            end
            ST_PS_WAIT_DONE: begin
                if (psdone) begin
                    step_cnt_d = w_step_nxt;
                    if (w_pos_done) begin
                        phase_pos_d  = (phase_pos_q == 7'(PHASE_POS - 1)) ? 7'd0
                                                                          : phase_pos_q + 7'd1;
                        settle_cnt_d = '0;
                        state_d      = ST_PS_SETTLE;
                    end else begin
                        state_d = ST_PS_ISSUE;
                    end
                end else if (w_tmo_hit) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_PS_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_PS_SETTLE: begin
                if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_PS_IDLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SET_W'(1);
                end
            end
            default: state_d = ST_PS_IDLE;
        endcase

        // A timeout abandons every queued request; otherwise a simultaneous
        // request and completion cancel out.
        if (w_tmo_hit) begin
            pending_d = '0;
        end else begin
            case ({w_req, w_pos_done})
                2'b10: begin
                    if (pending_q == PEND_MAX) begin
                        overflow_err_d = 1'b1;
                    end else begin
                        pending_d = pending_q + PEND_W'(1);
                    end
                end
                2'b01:   pending_d = pending_q - PEND_W'(1);
                default: pending_d = pending_q;
            endcase
        end

        // Loss of lock invalidates the phase position entirely.
        if (!mmcm_locked) begin
            state_d     = ST_PS_IDLE;
            pending_d   = '0;
            phase_pos_d = '0;
            step_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_PS_IDLE;
            pending_q      <= '0;
            phase_pos_q    <= '0;
            step_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            settle_cnt_q   <= '0;
            timeout_err_q  <= 1'b0;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            phase_pos_q    <= phase_pos_d;
            step_cnt_q     <= step_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            timeout_err_q  <= timeout_err_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign psen         = (state_q == ST_PS_ISSUE);
    assign psincdec     = INC_DIR;
    assign busy         = (state_q != ST_PS_IDLE) || (pending_q != '0);
    assign phase_pos    = phase_pos_q;
    assign pending      = pending_q;
    assign timeout_err  = timeout_err_q;
    assign overflow_err = overflow_err_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_phase_stepper.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_phase_stepper
// Description : Directed self-checking bench for adc_phase_stepper.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_phase_stepper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       adjust_phase = 1'b0;
    logic       mmcm_locked = 1'b1;
    logic       clr_err = 1'b0;
    logic       resp_done = 1'b0;
    logic       force_done = 1'b0;
    logic       psdone;
    logic       psen, psincdec, busy, timeout_err, overflow_err;
    logic [6:0] phase_pos;
    logic [3:0] pending;

    logic       adj3 = 1'b0;
    logic       done3 = 1'b0;
    logic       psen3, psincdec3, busy3, timeout3, overflow3;
    logic [6:0] phase3;
    logic [3:0] pending3;

    int checks = 0;
    int failures = 0;
    int resp_lat = 0;
    int psen_cnt = 0;
    int psen3_cnt = 0;
    int base;

    typedef struct {
        int pulses;
        int lat;
        int exp_pos;
    } vec_t;
    vec_t vecs[5];

    assign psdone = resp_done | force_done;

    adc_phase_stepper dut (
        .clk(clk), .rst(rst), .adjust_phase(adjust_phase), .mmcm_locked(mmcm_locked),
        .clr_err(clr_err), .psdone(psdone), .psen(psen), .psincdec(psincdec),
        .busy(busy), .phase_pos(phase_pos), .pending(pending),
        .timeout_err(timeout_err), .overflow_err(overflow_err)
    );

    adc_phase_stepper #(.STEPS_PER_POS(3)) dut3 (
        .clk(clk), .rst(rst), .adjust_phase(adj3), .mmcm_locked(mmcm_locked),
        .clr_err(clr_err), .psdone(done3), .psen(psen3), .psincdec(psincdec3),
        .busy(busy3), .phase_pos(phase3), .pending(pending3),
        .timeout_err(timeout3), .overflow_err(overflow3)
    );

    always #5 clk = ~clk;

    // MMCM model: psdone arrives resp_lat cycles after psen (0 = never).
    initial forever begin
        @(negedge clk);
        resp_done = 1'b0;
        if (psen && resp_lat > 0) begin
            repeat (resp_lat) @(negedge clk);
            resp_done = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        done3 = 1'b0;
        if (psen3) begin
            repeat (4) @(negedge clk);
            done3 = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (psen)  psen_cnt++;
        if (psen3) psen3_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse();
        @(negedge clk);
        adjust_phase = 1'b1;
        @(negedge clk);
        adjust_phase = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{pulses: 4,  lat: 1,  exp_pos: 5};
        vecs[1] = '{pulses: 20, lat: 10, exp_pos: 25};
        vecs[2] = '{pulses: 30, lat: 16, exp_pos: 55};
        vecs[3] = '{pulses: 1,  lat: 10, exp_pos: 0};
        vecs[4] = '{pulses: 3,  lat: 5,  exp_pos: 3};

        repeat (3) @(negedge clk);
        chk("rst_psen", int'(psen), 0);
        chk("rst_psincdec", int'(psincdec), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_phase", int'(phase_pos), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_errs", int'({timeout_err, overflow_err}), 0);
        rst = 1'b0;

        // Single position, psdone 12 cycles after psen.
        resp_lat = 12;
        pulse();
        chk("t1_pending_n1", int'(pending), 1);
        chk("t1_psen_n1", int'(psen), 0);
        @(negedge clk);
        chk("t1_psen_n2", int'(psen), 1);
        repeat (12) @(negedge clk);
        chk("t1_phase_before_done", int'(phase_pos), 0);
        @(negedge clk);
        chk("t1_phase_after", int'(phase_pos), 1);
        chk("t1_pending_after", int'(pending), 0);
        chk("t1_busy_settle", int'(busy), 1);
        repeat (7) @(negedge clk);
        chk("t1_busy_settle_end", int'(busy), 1);
        @(negedge clk);
        chk("t1_busy_idle", int'(busy), 0);
        chk("t1_psen_cnt", psen_cnt, 1);

        // Three fine steps per position on the second instance.
        @(negedge clk);
        adj3 = 1'b1;
        @(negedge clk);
        adj3 = 1'b0;
        @(negedge clk);
        chk("s3_psen_first", int'(psen3), 1);
        repeat (4) @(negedge clk);
        chk("s3_psen_wait", int'(psen3), 0);
        @(negedge clk);
        chk("s3_psen_second", int'(psen3), 1);
        chk("s3_phase_mid", int'(phase3), 0);
        repeat (5) @(negedge clk);
        chk("s3_psen_third", int'(psen3), 1);
        repeat (4) @(negedge clk);
        chk("s3_phase_before", int'(phase3), 0);
        @(negedge clk);
        chk("s3_phase_after", int'(phase3), 1);
        chk("s3_pending_after", int'(pending3), 0);
        repeat (10) @(negedge clk);
        chk("s3_busy", int'(busy3), 0);
        chk("s3_psen_cnt", psen3_cnt, 3);
        chk("s3_flags", int'({psincdec3, timeout3, overflow3}), 4);

        // Spaced pulse trains; the phase position wraps at 56.
        for (int r = 0; r < 5; r++) begin
            resp_lat = vecs[r].lat;
            base = psen_cnt;
            for (int p = 0; p < vecs[r].pulses; p++) begin
                pulse();
                repeat (23) @(negedge clk);
            end
            wait_idle($sformatf("vec%0d", r), 300);
            chk($sformatf("vec%0d_phase", r), int'(phase_pos), vecs[r].exp_pos);
            chk($sformatf("vec%0d_psen", r), psen_cnt - base, vecs[r].pulses);
            chk($sformatf("vec%0d_errs", r), int'({timeout_err, overflow_err}), 0);
        end

        // psdone withheld: timeout after DONE_TIMEOUT cycles drops the queue.
        resp_lat = 0;
        @(negedge clk);
        adjust_phase = 1'b1;
        @(negedge clk);
        @(negedge clk);
        adjust_phase = 1'b0;
        chk("tmo_psen", int'(psen), 1);
        chk("tmo_pending2", int'(pending), 2);
        repeat (64) @(negedge clk);
        chk("tmo_not_yet", int'(timeout_err), 0);
        chk("tmo_pending_hold", int'(pending), 2);
        @(negedge clk);
        chk("tmo_flag", int'(timeout_err), 1);
        chk("tmo_pending_clr", int'(pending), 0);
        chk("tmo_phase_kept", int'(phase_pos), 3);
        chk("tmo_busy", int'(busy), 0);
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("tmo_clr", int'(timeout_err), 0);

        // 20 back-to-back pulses saturate the queue at 15.
        resp_lat = 18;
        base = psen_cnt;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 15) begin
                chk("ovf_pending_full", int'(pending), 15);
                chk("ovf_flag_not_yet", int'(overflow_err), 0);
            end
            if (i == 18) begin
                chk("ovf_pending_sat", int'(pending), 15);
                chk("ovf_beats_clr", int'(overflow_err), 1);
            end
            adjust_phase = 1'b1;
            clr_err = (i == 17);
        end
        @(negedge clk);
        adjust_phase = 1'b0;
        clr_err = 1'b0;
        wait_idle("ovf", 1000);
        chk("ovf_positions", psen_cnt - base, 15);
        chk("ovf_phase", int'(phase_pos), 18);
        chk("ovf_flag_sticky", int'(overflow_err), 1);
        chk("ovf_no_tmo", int'(timeout_err), 0);

        // Lock lost during WAIT_DONE with three queued requests.
        resp_lat = 0;
        base = psen_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            adjust_phase = 1'b1;
        end
        @(negedge clk);
        adjust_phase = 1'b0;
        chk("lock_pending3", int'(pending), 3);
        mmcm_locked = 1'b0;
        @(negedge clk);
        chk("lock_phase0", int'(phase_pos), 0);
        chk("lock_pending0", int'(pending), 0);
        chk("lock_busy", int'(busy), 0);
        force_done = 1'b1;
        adjust_phase = 1'b1;
        @(negedge clk);
        adjust_phase = 1'b0;
        mmcm_locked = 1'b1;
        chk("lock_pulse_ignored", int'(pending), 0);
        chk("lock_sticky_kept", int'(overflow_err), 1);
        @(negedge clk);
        force_done = 1'b0;
        @(negedge clk);
        chk("lock_late_done_phase", int'(phase_pos), 0);
        chk("lock_late_done_busy", int'(busy), 0);
        chk("lock_psen_cnt", psen_cnt - base, 1);

        // Asynchronous reset in the middle of a shift.
        resp_lat = 5;
        pulse();
        wait_idle("pre_rst", 100);
        chk("pre_rst_phase", int'(phase_pos), 1);
        pulse();
        pulse();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_psen", int'(psen), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_phase", int'(phase_pos), 0);
        chk("arst_pending", int'(pending), 0);
        chk("arst_errs", int'({psincdec, timeout_err, overflow_err}), 4);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_idle", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/adc_phase_stepper.md
Name: adc_phase_stepper

Overview:
- Sits directly downstream of the ADC trainer, between its adjust_phase pulse output and the MMCM dynamic phase-shift port that clocks the ADC deserializers.
- Converts each adjust_phase pulse into STEPS_PER_POS MMCM fine-phase steps using the psen/psincdec/psdone handshake.
- Queues back-to-back requests, tracks the current phase position modulo PHASE_POS, and flags handshake timeouts and queue overflow.

Parameters:
- PHASE_POS, 56, number of phase positions per sweep; the position counter wraps at this value.
- STEPS_PER_POS, 1, number of MMCM fine steps issued per adjust_phase pulse (1..255).
- PEND_W, 4, width of the pending-request counter; saturates at 2^PEND_W-1.
- DONE_TIMEOUT, 64, clk cycles to wait for psdone after psen before declaring a timeout.
- SETTLE_CYCLES, 8, idle clk cycles inserted after each completed position before the next one starts.
- INC_DIR, 1'b1, value driven on psincdec (1 = increment phase).

Ports:
- clk  in  1  system clock; also drives the MMCM psclk.
- rst  in  1  reset, asynchronous, active-high.
- adjust_phase  in  1  single-cycle request to advance one position.
- mmcm_locked  in  1  MMCM lock status.
- clr_err  in  1  synchronous clear of the sticky flags.
- psdone  in  1  MMCM phase-shift done; single-cycle pulse.
- psen  out  1  MMCM phase-shift enable; single-cycle pulse.
- psincdec  out  1  MMCM shift direction.
- busy  out  1  high when state is not IDLE or pending is nonzero.
- phase_pos  out  7  current position, 0..PHASE_POS-1.
- pending  out  PEND_W  number of queued requests.
- timeout_err  out  1  sticky: psdone was not received within DONE_TIMEOUT.
- overflow_err  out  1  sticky: a request was dropped because the queue was full.

Behaviour:
- Reset values: psen=0, psincdec=INC_DIR, busy=0, phase_pos=0, pending=0, timeout_err=0, overflow_err=0; state=IDLE; all counters 0.
- psincdec is constant INC_DIR.
- pending update:
  - adjust_phase pulse: +1.
  - Position completion (last psdone of a position): -1.
  - Both in the same cycle: pending unchanged.
  - At the saturation value, an incoming pulse with no simultaneous completion is dropped and sets overflow_err.
- States:
  - IDLE: move to ISSUE when pending != 0 and mmcm_locked=1; step_cnt=0.
  - ISSUE: psen=1 for this cycle only; tmo_cnt=0; next state WAIT_DONE.
  - WAIT_DONE:
    - psdone=1: step_cnt+1. If step_cnt+1 == STEPS_PER_POS, the position is complete: phase_pos increments (PHASE_POS-1 wraps to 0), pending decrements, go to SETTLE. Otherwise go to ISSUE.
    - tmo_cnt reaches DONE_TIMEOUT-1 without psdone: set timeout_err, clear pending to 0, phase_pos unchanged, go to IDLE.
  - SETTLE: count SETTLE_CYCLES cycles, then go to IDLE.
- Latency: a pulse in cycle N gives pending=1 at N+1 and psen high in cycle N+2 (from IDLE, locked).
- psdone outside WAIT_DONE is ignored.
- mmcm_locked=0 in any state: next cycle go to IDLE and clear phase_pos, pending and step_cnt. Sticky flags are kept. New pulses are ignored while unlocked (no overflow set).
- clr_err clears both sticky flags; a new error event in the same cycle wins.
- With psdone latency up to 16 cycles, one position finishes within the trainer's 25-cycle relocate spacing for STEPS_PER_POS=1, so pending stays at most 1 in normal use.

Decomposition:
- Shared package adc_pkg:
  - state enum (ST_PS_IDLE, ST_PS_ISSUE, ST_PS_WAIT_DONE, ST_PS_SETTLE).
  - PHASE_POS_DEFAULT=56.
  - ADC_TEST_PATTERN constant.
- No sub-module needed; pending counter, step/timeout counters and FSM live in one module.

Test Plan:
- Single pulse, psdone returned 12 cycles after psen → psen pulses exactly once at N+2; phase_pos=1; pending returns to 0; busy low after SETTLE_CYCLES=8.
- 56 pulses spaced 25 cycles, psdone latency 10 → 56 psen pulses; phase_pos counts up to 55 and wraps to 0; no error flags set.
- STEPS_PER_POS=3, one pulse → three psen pulses, each issued only after the previous psdone; phase_pos increments once, after the third psdone.
- 20 pulses on consecutive cycles with PEND_W=4 → pending saturates at 15; overflow_err=1; exactly 15 positions are executed.
- psdone withheld → timeout_err=1 at 64 cycles after psen; pending=0; phase_pos unchanged; clr_err clears the flag.
- mmcm_locked dropped during WAIT_DONE with pending=3 → IDLE next cycle; phase_pos=0; pending=0; late psdone ignored; async rst mid-operation gives all outputs their reset values immediately.
